pdm_mic_emulator: RTL and testbench

- Responder end of the PDM microphone interface: replaces the physical mic and feeds the mic-clock generator / decimator chain with a known signal.
- Accepts signed PCM samples through a valid/ready FIFO and holds each sample for OSR mic clocks.
- Modulates each held sample with a first-order sigma-delta loop.
- Drives one PDM bit per mic_clk period, updated on mic_clk falling edges so the bit is stable when the receiver samples on rising edges.

---
 rtl/pdm_mic_emulator.sv | 140 ++++++++++++++
 tb/tb_pdm_mic_emulator.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_emulator.sv
// PDM microphone emulator: buffers signed PCM samples and plays each one out as OSR
// first-order sigma-delta bits, updated on synchronized mic_clk falling edges.
// Optional LFSR dither into the modulator accumulator when PDM_EMU_DITHER_EN is defined.
module pdm_mic_emulator #(
  parameter int WIDTH      = 16,
  parameter int OSR        = 256,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic signed [WIDTH-1:0]          sample_in,
  input  logic                             sample_valid_in,
  output logic                             sample_ready_out,
  input  logic                             mic_clk_in,
  output logic                             mic_data_out,
  output logic                             underflow_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_out
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TICK_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int ACC_W  = WIDTH + 2;
  localparam logic signed [ACC_W-1:0] FS = {3'b001, {(WIDTH-1){1'b0}}};

  function automatic logic signed [ACC_W-1:0] sext_sample(input logic signed [WIDTH-1:0] s);
    return {{2{s[WIDTH-1]}}, s};
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // mic_clk_in crossing: two synchronizer flops plus one delay flop for edge detect
  logic sync1_q, sync2_q, sync3_q;
  logic tick;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= mic_clk_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tick = sync3_q & ~sync2_q;

  logic signed [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [TICK_W-1:0]       tick_cnt_q;
  logic                    push, pop, reload, fifo_empty;

  assign sample_ready_out = (count_q < CNT_W'(FIFO_DEPTH));
  assign fifo_empty       = (count_q == '0);
  assign push             = sample_valid_in & sample_ready_out;
  assign reload           = tick & (tick_cnt_q == TICK_W'(OSR - 1));
  // Pop decision uses the registered count, so a same-cycle push never bypasses
  assign pop              = reload & ~fifo_empty;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= sample_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  logic signed [WIDTH-1:0] cur_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, fb, dith;
  logic                    data_q, armed_q, underflow_q;

`ifdef PDM_EMU_DITHER_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lfsr_q <= 16'hACE1;
    end else if (tick) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign dith = {{(ACC_W-4){lfsr_q[3]}}, lfsr_q[3:0]};
`else
  assign dith = '0;
`endif

  assign fb    = data_q ? FS : -FS;
  assign acc_d = acc_q + sext_sample(cur_q) - fb + dith;

  // Modulator step on a reload tick still uses the outgoing sample
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tick_cnt_q  <= TICK_W'(OSR - 1);
      cur_q       <= '0;
      acc_q       <= '0;
      data_q      <= 1'b0;
      armed_q     <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= reload & fifo_empty & armed_q;
      if (tick) begin
        acc_q      <= acc_d;
        data_q     <= ~acc_d[ACC_W-1];
        tick_cnt_q <= reload ? '0 : tick_cnt_q + 1'b1;
      end
      if (pop) begin
        cur_q   <= mem_q[rd_ptr_q];
        armed_q <= 1'b1;
      end
    end
  end

  assign mic_data_out   = data_q;
  assign underflow_out  = underflow_q;
  assign fifo_count_out = count_q;

endmodule

// File: tb/tb_pdm_mic_emulator.sv
// Bench for pdm_mic_emulator: randomized samples, integer sigma-delta reference model,
// scoreboard of expected PDM bits checked by an independent monitor process.
module tb_pdm_mic_emulator;
  localparam int     WIDTH = 16;
  localparam int     OSR   = 256;
  localparam int     DEPTH = 8;
  localparam longint FS    = 32768;

  bit                      clk;
  logic                    rst;
  logic signed [WIDTH-1:0] sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  bit                      mic_clk;
  logic                    mic_data;
  logic                    underflow;
  logic [3:0]              fifo_count;

  pdm_mic_emulator #(.WIDTH(WIDTH), .OSR(OSR), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid),
    .sample_ready_out (sample_ready),
    .mic_clk_in       (mic_clk),
    .mic_data_out     (mic_data),
    .underflow_out    (underflow),
    .fifo_count_out   (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: integer sigma-delta with a sample queue
  longint m_acc, m_cur;
  bit     m_bit, m_armed;
  int     m_cnt, m_tick, exp_uf, uf_at;
  longint m_fifo[$];
  int     reload_at[$];
  bit     exp_q[$];
  bit     obs[$];
  int     uf_cycles = 0;
  logic signed [WIDTH-1:0] pv[$];

  task automatic check(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cur = 0; m_bit = 0; m_armed = 0;
    m_cnt = OSR - 1; m_tick = 0; exp_uf = 0; uf_at = -1;
    m_fifo.delete(); reload_at.delete(); exp_q.delete(); obs.delete();
  endtask

  task automatic model_step();
    longint fb;
    fb = m_bit ? FS : -FS;
    m_acc = m_acc + m_cur - fb;
    m_bit = (m_acc >= 0);
    exp_q.push_back(m_bit);
    if (m_cnt == OSR - 1) begin
      m_cnt = 0;
      if (m_fifo.size() > 0) begin
        m_cur = m_fifo.pop_front();
        m_armed = 1;
        reload_at.push_back(m_tick);
      end else if (m_armed) begin
        exp_uf++;
        if (uf_at < 0) uf_at = m_tick;
      end
    end else begin
      m_cnt++;
    end
    m_tick++;
  endtask

  task automatic run_ticks(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      repeat (half) @(posedge clk);
      #2 mic_clk = 1'b1;
      repeat (half) @(posedge clk);
      #2 mic_clk = 1'b0;
      model_step();
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  // Back-to-back pushes of pv[], with expected acceptance from the model queue depth
  task automatic push_seq();
    bit exp_rdy;
    @(posedge clk);
    for (int i = 0; i < pv.size(); i++) begin
      #2;
      sample_in    = pv[i];
      sample_valid = 1'b1;
      exp_rdy = (m_fifo.size() < DEPTH);
      #1 check($sformatf("ready_push%0d", i), sample_ready, exp_rdy);
      @(posedge clk);
      if (exp_rdy) m_fifo.push_back(longint'(pv[i]));
    end
    #2 sample_valid = 1'b0;
    #1 check("fifo_count_after_push", fifo_count, m_fifo.size());
  endtask

  function automatic int ones(input int s, input int n);
    int c = 0;
    for (int i = 0; i < n; i++)
      if (s + i < obs.size()) c += obs[s + i];
    return c;
  endfunction

  // Monitor: each raw mic_clk fall produces a new bit three clk edges later
  initial begin
    bit e;
    forever begin
      @(negedge mic_clk);
      repeat (3) @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("pdm_unexpected_tick", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("pdm_bit", mic_data, e);
        obs.push_back(mic_data);
      end
    end
  end

  always @(negedge clk) if (underflow === 1'b1) uf_cycles++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, d7, dh, base;
    bit first5[5];
    first5 = '{1, 1, 0, 1, 0};
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mic_data", mic_data, 0);
    check("rst_ready", sample_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_underflow", underflow, 0);
    #2 rst = 1'b0;

    // Idle stream with zero sample, slow mic clock
    run_ticks(40, 16);
    for (int i = 0; i < 5; i++) check($sformatf("idle_seq%0d", i), obs[i], first5[i]);
    check("idle_no_underflow", uf_cycles, 0);
    check("idle_count", fifo_count, 0);

    // Nine pushes with mic clock held low: only eight fit
    pv = '{16'sh7FFF, 16'sh8000, 16'sh4000};
    for (int i = 0; i < 6; i++) pv.push_back(WIDTH'($urandom));
    push_seq();
    check("full_count", fifo_count, 8);
    check("full_ready", sample_ready, 0);

    run_ticks(2561 - 40, 8);
    d0 = ones(reload_at[0] + 1, 256);
    check("density_7fff_ge255", (d0 >= 255), 1);
    check("density_8000_le1", (ones(reload_at[1] + 1, 256) <= 1), 1);
    d7 = ones(reload_at[2] + 1, 256);
    check("density_4000_192pm1", (d7 >= 191 && d7 <= 193), 1);
    d7 = ones(reload_at[7] + 1, 256);
    dh = ones(uf_at + 1, 256);
    check("density_held_after_underflow", (dh >= d7 - 1 && dh <= d7 + 1), 1);
    check("underflow_cycles", uf_cycles, exp_uf);
    check("drained_count", fifo_count, 0);

    // Mid-stream async reset with FIFO occupied and data high
    pv = '{WIDTH'($urandom), WIDTH'($urandom)};
    push_seq();
    for (int i = 0; i < 8 && !m_bit; i++) run_ticks(1, 8);
    check("pre_reset_data", mic_data, m_bit);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_data", mic_data, 0);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_ready", sample_ready, 1);
    model_reset();
    base = uf_cycles;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    run_ticks(20, 8);
    for (int i = 0; i < 5; i++) check($sformatf("restart_seq%0d", i), obs[i], first5[i]);
    check("restart_no_underflow", uf_cycles - base, 0);
    check("restart_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
